cn_host_sequencer: RTL and testbench

//  Host-side initiator for the CryptoNight core's register/memory slave ports. Checks core version,

---
 rtl/cn_host_sequencer.sv | 171 +++++++++++++++++
 tb/tb_cn_host_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cn_host_sequencer.sv
// Host-side initiator for the CryptoNight core: version check, h0/op-code load, start,
// completion wait and scratchpad readback as a 128b stream.
module cn_host_sequencer #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter logic [31:0] VERSION    = 32'h19070416,
  parameter int unsigned TIMEOUT    = 2**24
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cmd_start,
  input  logic [7:0]            i_cfg_code_words,
  input  logic [ADDR_WIDTH+1:0] i_cfg_rd_base,
  input  logic [15:0]           i_cfg_rd_count,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [31:0]           i_in_data,
  output logic                  o_res_valid,
  input  logic                  i_res_ready,
  output logic [127:0]          o_res_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [1:0]            o_err_code,
  output logic [9:0]            o_reg_address,
  output logic                  o_reg_write,
  output logic [31:0]           o_reg_wrdata,
  input  logic [31:0]           i_reg_rddata,
  output logic [ADDR_WIDTH+1:0] o_mem_address,
  output logic                  o_mem_write,
  output logic [127:0]          o_mem_wrdata,
  input  logic [127:0]          i_mem_rddata,
  input  logic                  i_sts_ml_finished
);

  localparam int unsigned TW        = $clog2(TIMEOUT + 1);
  localparam logic [7:0]  MAX_CODE  = 8'd140;
  localparam logic [7:0]  LAST_H0   = 8'd27;
  localparam logic [9:0]  CTRL_REG  = 10'h200;

  typedef enum logic [3:0] {
    IDLE, VER_RD, VER_CHK, LOAD_H0, LOAD_CODE, START,
    WAIT_DONE, RD_ISSUE, RD_CAP, RD_WAIT, DONE
  } state_t;

  state_t                r_state, w_next;
  logic [7:0]            r_code_n;
  logic [7:0]            r_idx;
  logic [ADDR_WIDTH+1:0] r_cur;
  logic [15:0]           r_rem;
  logic [1:0]            r_err;
  logic [TW-1:0]         r_tmo;
  logic                  r_prev;
  logic [127:0]          r_res_data;
  logic                  w_rise;
  logic                  w_tmo_hit;

  assign w_rise    = i_sts_ml_finished & ~r_prev;
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // NOTE: every output and w_next gets a default first, so no path can infer a latch.
  always_comb begin
    w_next        = r_state;
    o_in_ready    = 1'b0;
    o_reg_write   = 1'b0;
    o_reg_address = '0;
    o_reg_wrdata  = '0;
    o_mem_address = '0;
    unique case (r_state)
      IDLE:      if (i_cmd_start) w_next = VER_RD;
      VER_RD: begin
        o_reg_address = CTRL_REG;
        w_next        = VER_CHK;
      end
      VER_CHK:   w_next = (i_reg_rddata == VERSION) ? LOAD_H0 : DONE;
      LOAD_H0: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          o_reg_write   = 1'b1;
          o_reg_address = {2'b01, 3'b000, r_idx[4:1], r_idx[0]};
          o_reg_wrdata  = i_in_data;
          if (r_idx == LAST_H0) w_next = (r_code_n == 8'd0) ? START : LOAD_CODE;
        end
      end
      LOAD_CODE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          o_reg_write   = 1'b1;
          o_reg_address = {2'b00, r_idx};
          o_reg_wrdata  = i_in_data;
          if (r_idx == r_code_n - 8'd1) w_next = START;
        end
      end
      START: begin
        o_reg_write   = 1'b1;
        o_reg_address = CTRL_REG;
        o_reg_wrdata  = 32'h1;
        w_next        = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (w_rise)         w_next = (r_rem == 16'd0) ? DONE : RD_ISSUE;
        else if (w_tmo_hit) w_next = DONE;
      end
      RD_ISSUE: begin
        o_mem_address = r_cur;
        w_next        = RD_CAP;
      end
      RD_CAP:    w_next = RD_WAIT;
      RD_WAIT:   if (i_res_ready) w_next = (r_rem == 16'd1) ? DONE : RD_ISSUE;
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_code_n   <= '0;
      r_idx      <= '0;
      r_cur      <= '0;
      r_rem      <= '0;
      r_err      <= '0;
      r_tmo      <= '0;
      r_prev     <= 1'b0;
      r_res_data <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (i_cmd_start) begin
          r_code_n <= (i_cfg_code_words > MAX_CODE) ? MAX_CODE : i_cfg_code_words;
          r_cur    <= i_cfg_rd_base;
          r_rem    <= i_cfg_rd_count;
          r_err    <= 2'd0;
          r_idx    <= '0;
        end
        VER_CHK:   if (i_reg_rddata != VERSION) r_err <= 2'd1;
        LOAD_H0:   if (i_in_valid) r_idx <= (r_idx == LAST_H0) ? 8'd0 : r_idx + 8'd1;
        LOAD_CODE: if (i_in_valid) r_idx <= r_idx + 8'd1;
        START: begin
          // A level left high by a previous job must not count as this job's edge.
          r_tmo  <= '0;
          r_prev <= i_sts_ml_finished;
        end
        WAIT_DONE: begin
          r_prev <= i_sts_ml_finished;
          if (!w_rise) begin
            if (w_tmo_hit) r_err <= 2'd2;
            else           r_tmo <= r_tmo + 1'b1;
          end
        end
        RD_CAP:    r_res_data <= i_mem_rddata;
        RD_WAIT: if (i_res_ready) begin
          r_cur <= r_cur + 1'b1;
          r_rem <= r_rem - 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_res_valid  = (r_state == RD_WAIT);
  assign o_res_data   = r_res_data;
  assign o_busy       = (r_state != IDLE);
  assign o_done       = (r_state == DONE);
  assign o_err_code   = r_err;
  assign o_mem_write  = 1'b0;
  assign o_mem_wrdata = '0;

endmodule

// File: tb/tb_cn_host_sequencer.sv
// Directed bench for cn_host_sequencer: register/memory BFMs, a write scoreboard and a readback scoreboard.
module tb_cn_host_sequencer;

  localparam int          AW  = 15;
  localparam int          MW  = AW + 2;
  localparam logic [31:0] VER = 32'h19070416;
  localparam int          TMO = 1200;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          i_reset, i_cmd_start, i_in_valid, i_res_ready, i_sts_ml_finished;
  logic [7:0]    i_cfg_code_words;
  logic [MW-1:0] i_cfg_rd_base;
  logic [15:0]   i_cfg_rd_count;
  logic [31:0]   i_in_data;
  logic          o_in_ready, o_res_valid, o_busy, o_done, o_reg_write, o_mem_write;
  logic [127:0]  o_res_data, o_mem_wrdata;
  logic [1:0]    o_err_code;
  logic [9:0]    o_reg_address;
  logic [31:0]   o_reg_wrdata;
  logic [31:0]   i_reg_rddata = '0;
  logic [MW-1:0] o_mem_address;
  logic [127:0]  i_mem_rddata = '0;

  logic [31:0]   version_val;
  wr_t           wq[$];
  logic [127:0]  rq[$];
  int n_checks = 0, n_errors = 0, n_writes = 0, n_starts = 0, n_reads = 0, cyc = 0, start_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  cn_host_sequencer #(.ADDR_WIDTH(AW), .VERSION(VER), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_cmd_start(i_cmd_start),
    .i_cfg_code_words(i_cfg_code_words), .i_cfg_rd_base(i_cfg_rd_base), .i_cfg_rd_count(i_cfg_rd_count),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_data(o_res_data),
    .o_busy(o_busy), .o_done(o_done), .o_err_code(o_err_code),
    .o_reg_address(o_reg_address), .o_reg_write(o_reg_write), .o_reg_wrdata(o_reg_wrdata),
    .i_reg_rddata(i_reg_rddata), .o_mem_address(o_mem_address), .o_mem_write(o_mem_write),
    .o_mem_wrdata(o_mem_wrdata), .i_mem_rddata(i_mem_rddata), .i_sts_ml_finished(i_sts_ml_finished)
  );

  function automatic logic [127:0] mem_word(input logic [MW-1:0] a);
    logic [31:0] w;
    w = 32'(a);
    return {32'hC0DE0000 ^ w, 32'h11110000 + w, ~w, w * 32'd3};
  endfunction

  // Registered-read slave models.
  always @(posedge clk) begin
    i_reg_rddata <= (o_reg_address == 10'h200) ? version_val : 32'hDEAD0000;
    i_mem_rddata <= mem_word(o_mem_address);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: register writes and accepted readback words.
  always @(negedge clk) begin : monitor
    wr_t         e;
    logic [127:0] r;
    if (o_reg_write) begin
      n_writes++;
      if (o_reg_address == 10'h200) begin
        n_starts++;
        start_cyc = cyc;
      end
      check("wr_expected", wq.size() != 0, 1'b1);
      if (wq.size() != 0) begin
        e = wq.pop_front();
        check("wr_addr", o_reg_address, e.a);
        check("wr_data", o_reg_wrdata, e.d);
      end
    end
    if (o_res_valid && i_res_ready) begin
      n_reads++;
      check("rd_expected", rq.size() != 0, 1'b1);
      if (rq.size() != 0) begin
        r = rq.pop_front();
        check("rd_data", o_res_data, r);
      end
    end
  end

  initial begin
    i_res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 i_res_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not reach its end, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic start_job(input logic [7:0] cw, input logic [MW-1:0] base, input logic [15:0] cnt);
    i_cfg_code_words = cw;
    i_cfg_rd_base    = base;
    i_cfg_rd_count   = cnt;
    i_cmd_start      = 1'b1;
    @(posedge clk); #1;
    i_cmd_start      = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] data, input logic [9:0] addr, input bit gap);
    int t;
    if (gap) begin
      i_in_valid = 1'b0;
      @(posedge clk); #1;
    end
    wq.push_back('{a: addr, d: data});
    i_in_valid = 1'b1;
    i_in_data  = data;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!o_in_ready && t < 100);
    check("in_ready_seen", o_in_ready, 1'b1);
    @(posedge clk); #1;
    i_in_valid = 1'b0;
  endtask

  task automatic load_all(input int cw, input bit gaps);
    for (int k = 0; k < 28; k++)
      send_word(32'h9E3779B9 * 32'(k + 1), 10'h100 + 10'(k), gaps && k[0]);
    for (int j = 0; j < cw; j++)
      send_word(32'hB0000000 ^ (32'(j) * 32'h01010101), 10'(j), gaps && j[0]);
    wq.push_back('{a: 10'h200, d: 32'h1});
  endtask

  task automatic wait_start(input int s0);
    int t;
    t = 0;
    while (n_starts == s0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("start_seen", n_starts - s0, 1);
  endtask

  task automatic pulse_sts();
    repeat (5) @(posedge clk);
    #1 i_sts_ml_finished = 1'b1;
    @(posedge clk); #1;
    i_sts_ml_finished = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!o_done && t < budget);
    check("done_seen", o_done, 1'b1);
  endtask

  task automatic end_job(input string tag, input logic [1:0] exp_err);
    check({tag, "_err"}, o_err_code, exp_err);
    @(negedge clk);
    check({tag, "_done_1cyc"}, o_done, 1'b0);
    check({tag, "_idle"}, o_busy, 1'b0);
    check({tag, "_err_held"}, o_err_code, exp_err);
    check({tag, "_wq_empty"}, wq.size(), 0);
    check({tag, "_rq_empty"}, rq.size(), 0);
  endtask

  initial begin
    int w0, s0, r0;
    logic [MW-1:0] rd_addr[4];
    i_reset = 1'b1; i_cmd_start = 1'b0; i_in_valid = 1'b0; i_in_data = '0;
    i_sts_ml_finished = 1'b0; i_cfg_code_words = '0; i_cfg_rd_base = '0; i_cfg_rd_count = '0;
    version_val = VER;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_err", o_err_code, 2'd0);
    check("rst_in_ready", o_in_ready, 1'b0);
    check("rst_reg_bus", {o_reg_write, o_reg_address, o_reg_wrdata}, '0);
    check("rst_mem_bus", {o_mem_write, o_mem_address, o_mem_wrdata}, '0);
    check("rst_res_valid", o_res_valid, 1'b0);

    // 1: version mismatch
    version_val = 32'h12345678;
    w0 = n_writes;
    @(posedge clk); #1;
    start_job(8'd5, '0, 16'd2);
    @(negedge clk);
    check("t1_busy", o_busy, 1'b1);
    wait_done(50);
    check("t1_writes", n_writes - w0, 0);
    end_job("t1", 2'd1);
    version_val = VER;

    // 2: full load, continuous stream
    w0 = n_writes; s0 = n_starts;
    start_job(8'd140, '0, 16'd0);
    load_all(140, 1'b0);
    wait_start(s0);
    check("t2_writes", n_writes - w0, 169);
    pulse_sts();
    wait_done(50);
    end_job("t2", 2'd0);

    // 3: stream gaps, code count above the clamp
    w0 = n_writes; s0 = n_starts;
    start_job(8'd200, '0, 16'd0);
    load_all(140, 1'b1);
    wait_start(s0);
    check("t3_writes", n_writes - w0, 169);
    pulse_sts();
    wait_done(50);
    end_job("t3", 2'd0);

    // 4: readback across the address wrap
    rd_addr = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001};
    for (int i = 0; i < 4; i++) rq.push_back(mem_word(rd_addr[i]));
    s0 = n_starts; r0 = n_reads;
    start_job(8'd3, 17'h1FFFE, 16'd4);
    load_all(3, 1'b0);
    wait_start(s0);
    repeat (1000) @(posedge clk);
    #1 i_sts_ml_finished = 1'b1;
    @(posedge clk); #1;
    i_sts_ml_finished = 1'b0;
    wait_done(200);
    check("t4_reads", n_reads - r0, 4);
    end_job("t4", 2'd0);

    // 5a: timeout with sts low; 5b: sts already high at entry
    for (int pass = 0; pass < 2; pass++) begin
      i_sts_ml_finished = (pass == 1);
      s0 = n_starts; r0 = n_reads;
      start_job(8'd0, '0, 16'd5);
      load_all(0, 1'b0);
      wait_start(s0);
      wait_done(TMO + 100);
      check("t5_latency", cyc - start_cyc, TMO + 1);
      check("t5_reads", n_reads - r0, 0);
      end_job("t5", 2'd2);
      i_sts_ml_finished = 1'b0;
    end

    // 6: reset during LOAD_H0, then a clean job
    s0 = n_starts;
    start_job(8'd4, '0, 16'd1);
    for (int k = 0; k < 10; k++) send_word(32'h600D0000 + 32'(k), 10'h100 + 10'(k), 1'b0);
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    @(negedge clk);
    check("t6_busy", o_busy, 1'b0);
    check("t6_in_ready", o_in_ready, 1'b0);
    check("t6_wq_empty", wq.size(), 0);
    repeat (5) @(negedge clk);
    check("t6_no_start", n_starts - s0, 0);
    rq.push_back(mem_word(17'h00123));
    start_job(8'd2, 17'h00123, 16'd1);
    load_all(2, 1'b0);
    wait_start(s0);
    pulse_sts();
    wait_done(100);
    end_job("t6", 2'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
